red_serial_comparator: RTL and testbench

- Bit-serial magnitude comparator ("red") for two unsigned words, palabraA and palabraB.
- Scans the words right-to-left, from LSB to MSB, one bit per clock.
- After a full scan, drives Z high when palabraA > palabraB.
- Free-running leaf block: continuously re-captures its inputs and refreshes Z once per comparison period.

---
 rtl/red_serial_comparator.sv | 92 +++++++++
 tb/tb_red_serial_comparator.sv | 115 +++++++++++
 2 files changed

// File: rtl/red_serial_comparator.sv
// rtl/red_serial_comparator.sv - bit-serial unsigned magnitude comparator, LSB first
//
// Free-running: LOAD captures both operands, then WIDTH COMPARE cycles scan
// them LSB to MSB. The last compare edge refreshes Z and pulses done, and the
// next edge is LOAD again, giving a period of WIDTH+1 cycles.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   palabraA  operand A (unsigned, WIDTH bits)
//   palabraB  operand B (unsigned, WIDTH bits)
//   Z         registered result, 1 when captured A > captured B
//   done      one-cycle pulse on the edge that refreshed Z
module red_serial_comparator #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] palabraA,
  input  logic [WIDTH-1:0] palabraB,
  output logic             Z,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    LOAD,
    COMPARE
  } stateT;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } relT;

  stateT            state;
  relT              relation;
  relT              nextRelation;
  logic [CW-1:0]    bitCount;
  logic [WIDTH-1:0] shiftA;
  logic [WIDTH-1:0] shiftB;

  // Later (more significant) bits overwrite the relation, so the value left
  // after the MSB is the relation at the most significant differing bit.
  always_comb begin
    nextRelation = relation;
    if (shiftA[0] && !shiftB[0]) begin
      nextRelation = REL_GT;
    end else if (!shiftA[0] && shiftB[0]) begin
      nextRelation = REL_LT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      relation <= REL_EQ;
      bitCount <= '0;
      shiftA   <= '0;
      shiftB   <= '0;
      Z        <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          shiftA   <= palabraA;
          shiftB   <= palabraB;
          relation <= REL_EQ;
          bitCount <= '0;
          state    <= COMPARE;
        end
        COMPARE: begin
          relation <= nextRelation;
          shiftA   <= shiftA >> 1;
          shiftB   <= shiftB >> 1;
          bitCount <= bitCount + CW'(1);
          if (bitCount == LAST_BIT) begin
            Z     <= (nextRelation == REL_GT);
            done  <= 1'b1;
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_red_serial_comparator.sv
// tb/tb_red_serial_comparator.sv - directed self-checking bench for red_serial_comparator
module tb_red_serial_comparator;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] palabraA;
  logic [2:0] palabraB;
  logic       Z;
  logic       done;

  int checkCount = 0;
  int failCount  = 0;
  logic zHeld;

  red_serial_comparator #(.WIDTH(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .palabraA (palabraA),
    .palabraB (palabraB),
    .Z        (Z),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("FAIL %s: observed %0b expected %0b", tag, observed, expected);
    end
  endtask

  // One full period starting at the LOAD edge. Z must hold its previous value
  // until the fourth edge, where done pulses and Z takes expZ.
  task automatic runPeriod(input logic [2:0] a, input logic [2:0] b,
                           input logic expZ, input string tag);
    palabraA = a;
    palabraB = b;
    for (int i = 0; i < 3; i++) begin
      step();
      check({tag, " done low"}, done, 1'b0);
      check({tag, " Z held"}, Z, zHeld);
    end
    step();
    check({tag, " done pulse"}, done, 1'b1);
    check({tag, " Z"}, Z, expZ);
    zHeld = expZ;
  endtask

  initial begin
    reset    = 1'b1;
    palabraA = 3'b000;
    palabraB = 3'b000;
    zHeld    = 1'b0;

    step();
    step();
    check("reset Z", Z, 1'b0);
    check("reset done", done, 1'b0);

    reset = 1'b0;
    runPeriod(3'b001, 3'b010, 1'b0, "a001_b010 p1");
    runPeriod(3'b001, 3'b010, 1'b0, "a001_b010 p2");

    runPeriod(3'b110, 3'b011, 1'b1, "msb dominance");
    runPeriod(3'b101, 3'b101, 1'b0, "equal");
    runPeriod(3'b111, 3'b000, 1'b1, "a111_b000");
    runPeriod(3'b000, 3'b111, 1'b0, "a000_b111");

    // Operands changed during COMPARE must not affect the current period.
    palabraA = 3'b100;
    palabraB = 3'b011;
    step();
    check("capture load done", done, 1'b0);
    palabraA = 3'b000;
    palabraB = 3'b111;
    step();
    step();
    check("capture mid Z held", Z, 1'b0);
    step();
    check("capture done", done, 1'b1);
    check("capture Z", Z, 1'b1);
    zHeld = 1'b1;
    runPeriod(3'b000, 3'b111, 1'b0, "after capture");

    // Reset in the middle of a scan clears Z and restarts a full period.
    runPeriod(3'b111, 3'b000, 1'b1, "pre reset");
    step();
    step();
    reset = 1'b1;
    step();
    check("mid reset Z", Z, 1'b0);
    check("mid reset done", done, 1'b0);
    reset = 1'b0;
    zHeld = 1'b0;
    runPeriod(3'b111, 3'b000, 1'b1, "post reset");

    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        runPeriod(3'(a), 3'(b), (a > b) ? 1'b1 : 1'b0, $sformatf("sweep a%0d b%0d", a, b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
